pwm_duty_sequencer: RTL and testbench
=====================================

// Module: pwm_duty_sequencer
// PURPOSE
//  Owns the PWM period counter and compare datapath and sequences duty changes on it.
//  Accepts a target duty code over a valid/ready handshake.
//  Moves the live duty toward the target only at period wrap, so every PWM period is glitch-free.
//  Feeds pwm_out to the LED/motor stage; software or switch logic drives the request side.
// PARAMETERS
//  CBITS      19  counter width; must be >= DBITS+2
//  DBITS      4   duty code width
//  INIT_DUTY  0   duty code loaded at reset
// PORTS
//  clk        in   1      single clock, posedge
//  rst        in   1      asynchronous, active-high reset
//  req_valid  in   1      duty request valid
//  req_duty   in   DBITS  requested duty code
//  req_ready  out  1      request accepted when req_valid & req_ready
//  cur_duty   out  DBITS  duty code in force this period
//  busy       out  1      sequence in progress (state != IDLE)
//  done       out  1      one-cycle pulse: target reached
//  period_tick out 1      high while cnt == 2^CBITS-1 (wrap cycle)
//  pwm_out    out  1      registered PWM output
// BEHAVIOUR
//  Compare threshold:
//   thr(d) = {1'b0, d, 1'b1, (CBITS-DBITS-2)'b0}.
//   Extremes: lb = thr(0), ub = thr(all ones). Always lb <= thr(cur_duty) <= ub.
//  Counter:
//   - cnt free-runs +1 per clk, modulo 2^CBITS.
//   - period_tick is combinational: (cnt == max).
//  Output:
//   - pwm_out <= (cnt < thr(cur_duty)), one cycle of latency.
//   - Exactly thr(cur_duty) high cycles per period.
//  Reset (rst high, immediate):
//   - cnt = 0, cur_duty = INIT_DUTY, state = IDLE, pwm_out = 0, done = 0.
//   - req_ready forced 0 while rst is high. Any pending target is discarded.
//  FSM:
//   - IDLE: req_ready = 1. On accept: tgt <= req_duty, go to RAMP.
//   - RAMP: req_ready = 0, busy = 1. cur_duty changes only on wrap cycles:
//     - cur_duty == tgt: go to IDLE; done = 1 for the following cycle.
//     - cur_duty < tgt: cur_duty += 1.
//     - cur_duty > tgt: cur_duty -= 1.
//  Glitch-free update:
//   - A new cur_duty registered at the wrap cycle is first compared at cnt == 0.
//   - No mid-period duty change.
//  Boundary cases:
//   - Accept during a wrap cycle: that wrap is not used for stepping; the first step is at the next wrap.
//   - Request equal to cur_duty: done after the first wrap; cur_duty unchanged.
//   - Steps never overshoot tgt and never wrap the duty code (saturating, monotone toward tgt).
//   - req_valid with req_ready low: ignored. Requester holds the request.
// CONFIGURATION
//  PWM_SEQ_RAMP_EN
//   - Defined: one duty step per period, as above.
//   - Undefined: at the first wrap in RAMP, cur_duty <= tgt in one jump; done follows the next wrap.
//  Handshake, reset and glitch-free rules are identical in both builds.
// TESTING (CBITS=8, DBITS=4, INIT_DUTY=0 -> thr(d) = d*8+4, period 256)
//  1. Hold rst for 3 cycles, then release.
//     - During reset: pwm_out = 0, cur_duty = 0, req_ready = 0.
//     - Each period after release: pwm_out high for 4 cycles.
//  2. RAMP_EN: request 3 from duty 0.
//     - cur_duty = 1, 2, 3 at wraps 1, 2, 3.
//     - done pulses after wrap 4; busy = 1 throughout; pwm high 12, 20, 28 cycles per period.
//  3. RAMP_EN: from duty 5, request 2.
//     - cur_duty = 4, 3, 2 on successive wraps; done after the 4th wrap.
//     - Threshold never exceeds 44.
//  4. Request 7 while cur_duty = 7.
//     - done after the first wrap; cur_duty stays 7.
//     - A second request during busy is not accepted.
//  5. Assert rst mid-ramp (cur_duty = 2, target 9).
//     - Same cycle: cur_duty = 0, busy = 0, pwm_out = 0.
//     - After release, the old target is not resumed.
//  6. No macro: request 12 from duty 0.
//     - cur_duty = 12 at the first wrap; done after the second wrap.
//     - pwm high 100 cycles per period.

Source files
------------

// File: rtl/pwm_duty_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pwm_duty_sequencer
// Description : Free-running PWM counter/compare with a handshake-fed duty
//               sequencer that only updates the live duty on period wrap.
//               Build option PWM_SEQ_RAMP_EN: step one code per period
//               (defined) or jump straight to target (undefined).
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_duty_sequencer #(
    parameter int CBITS     = 19,
    parameter int DBITS     = 4,
    parameter int INIT_DUTY = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic [DBITS-1:0] req_duty,
    output logic             req_ready,
    output logic [DBITS-1:0] cur_duty,
    output logic             busy,
    output logic             done,
    output logic             period_tick,
    output logic             pwm_out
);

    localparam int               C_SHIFT   = CBITS - DBITS - 2;
    localparam logic [CBITS-1:0] C_CNT_MAX = '1;
    localparam logic [DBITS-1:0] C_INIT    = DBITS'(INIT_DUTY);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RAMP = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CBITS-1:0]   cnt_q;
    logic [DBITS-1:0]   cur_duty_q, cur_duty_d;
    logic [DBITS-1:0]   tgt_q, tgt_d;
    logic               done_q, done_d;
    logic               pwm_q;
    logic               w_wrap;
    logic [CBITS-1:0]   w_thr;

    assign w_wrap = (cnt_q == C_CNT_MAX);
    // {0, d, 1, 0...}: the leading zero is implied by zero-extension.
    assign w_thr  = CBITS'({cur_duty_q, 1'b1}) << C_SHIFT;

    always_comb begin
        state_d    = state_q;
        tgt_d      = tgt_q;
        cur_duty_d = cur_duty_q;
        done_d     = 1'b0;
        req_ready  = 1'b0;
        case (state_q)
            S_IDLE: begin
                req_ready = ~rst;
                if (req_valid && !rst) begin
                    tgt_d   = req_duty;
                    state_d = S_RAMP;
                end
            end
            S_RAMP: begin
                if (w_wrap) begin
                    if (cur_duty_q == tgt_q) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
`ifdef PWM_SEQ_RAMP_EN
                    else if (cur_duty_q < tgt_q) begin
                        cur_duty_d = cur_duty_q + 1'b1;
                    end else begin
                        cur_duty_d = cur_duty_q - 1'b1;
                    end
`else
                    else begin
                        cur_duty_d = tgt_q;
                    end
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            cur_duty_q <= C_INIT;
            tgt_q      <= C_INIT;
            done_q     <= 1'b0;
            pwm_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_q + 1'b1;
            cur_duty_q <= cur_duty_d;
            tgt_q      <= tgt_d;
            done_q     <= done_d;
            pwm_q      <= (cnt_q < w_thr);
        end
    end

    assign cur_duty    = cur_duty_q;
    assign busy        = (state_q == S_RAMP);
    assign done        = done_q;
    assign period_tick = w_wrap;
    assign pwm_out     = pwm_q;

endmodule
`default_nettype wire

// File: tb/tb_pwm_duty_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pwm_duty_sequencer
// Description : Directed, table-driven bench for pwm_duty_sequencer with
//               CBITS=8, DBITS=4 (thr(d) = 8*d + 4, period 256).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_duty_sequencer;

    localparam int CBITS  = 8;
    localparam int DBITS  = 4;
    localparam int PERIOD = 256;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid;
    logic [DBITS-1:0] req_duty;
    logic             req_ready;
    logic [DBITS-1:0] cur_duty;
    logic             busy;
    logic             done;
    logic             period_tick;
    logic             pwm_out;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [3:0] duty;
        int         first;
        int         wraps;
        int         fin;
        bit         at_wrap;
    } vec_t;

    vec_t vecs[5];

    pwm_duty_sequencer #(
        .CBITS     (CBITS),
        .DBITS     (DBITS),
        .INIT_DUTY (0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_duty    (req_duty),
        .req_ready   (req_ready),
        .cur_duty    (cur_duty),
        .busy        (busy),
        .done        (done),
        .period_tick (period_tick),
        .pwm_out     (pwm_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_tick(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < PERIOD + 8; i++) begin
            @(negedge clk);
            if (period_tick) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic measure_high(input string name, input int exp);
        bit ok;
        int hi;
        hi = 0;
        wait_tick(ok);
        check({name, "_tick_seen"}, int'(ok), 1);
        for (int i = 0; i < PERIOD; i++) begin
            @(negedge clk);
            if (pwm_out) hi++;
        end
        check(name, hi, exp);
    endtask

    task automatic run_req(input vec_t v, input int prev);
        bit ok, tick, seen_done, busy_ok, ready_ok;
        int wraps, cyc;
        wraps = 0; cyc = 0; seen_done = 0; busy_ok = 1; ready_ok = 1;
        if (v.at_wrap) begin
            wait_tick(ok);
            check("wrap_wait", int'(ok), 1);
        end
        req_valid = 1'b1;
        req_duty  = v.duty;
        @(negedge clk);
        check("accept_busy", int'(busy), 1);
        if (v.at_wrap) check("wrap_accept_hold", int'(cur_duty), prev);
        // Keep a conflicting request asserted while busy; it must be ignored.
        req_duty = ~v.duty;
        while (!seen_done && cyc < 18 * PERIOD) begin
            tick = period_tick;
            @(negedge clk);
            cyc++;
            if (tick) begin
                wraps++;
                if (wraps == 1) check("first_wrap_duty", int'(cur_duty), v.first);
            end
            if (done) seen_done = 1'b1;
            else begin
                if (!busy) busy_ok = 1'b0;
                if (req_ready) ready_ok = 1'b0;
            end
        end
        req_valid = 1'b0;
        check("done_seen", int'(seen_done), 1);
        check("wraps_to_done", wraps, v.wraps);
        check("final_duty", int'(cur_duty), v.fin);
        check("busy_held", int'(busy_ok), 1);
        check("ready_low_busy", int'(ready_ok), 1);
        check("busy_at_done", int'(busy), 0);
        @(negedge clk);
        check("done_one_cycle", int'(done), 0);
        check("idle_after_done", int'(busy), 0);
        measure_high("pwm_high", v.fin * 8 + 4);
    endtask

    initial begin
        #(400000 * 10);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok, tick, quiet;
        int prev, wraps, need;

`ifdef PWM_SEQ_RAMP_EN
        vecs[0] = '{4'd3,  1, 4,  3, 1'b0};
        vecs[1] = '{4'd3,  3, 1,  3, 1'b0};
        vecs[2] = '{4'd5,  4, 3,  5, 1'b1};
        vecs[3] = '{4'd2,  4, 4,  2, 1'b0};
        vecs[4] = '{4'd0,  1, 3,  0, 1'b0};
        need    = 2;
`else
        vecs[0] = '{4'd12, 12, 2, 12, 1'b0};
        vecs[1] = '{4'd12, 12, 1, 12, 1'b0};
        vecs[2] = '{4'd3,   3, 2,  3, 1'b1};
        vecs[3] = '{4'd15, 15, 2, 15, 1'b0};
        vecs[4] = '{4'd0,   0, 2,  0, 1'b0};
        need    = 1;
`endif

        rst = 1'b1; req_valid = 1'b1; req_duty = 4'd9;
        repeat (2) @(negedge clk);
        check("rst_pwm", int'(pwm_out), 0);
        check("rst_duty", int'(cur_duty), 0);
        check("rst_ready", int'(req_ready), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b0;
        measure_high("reset_pwm_high", 4);
        check("post_rst_idle", int'(busy), 0);

        prev = 0;
        for (int i = 0; i < 5; i++) begin
            run_req(vecs[i], prev);
            prev = vecs[i].fin;
        end

        // Reset in the middle of a ramp toward 9.
        req_valid = 1'b1; req_duty = 4'd9;
        @(negedge clk);
        req_valid = 1'b0;
        wraps = 0;
        for (int i = 0; i < 4 * PERIOD && wraps < need; i++) begin
            tick = period_tick;
            @(negedge clk);
            if (tick) wraps++;
        end
`ifdef PWM_SEQ_RAMP_EN
        check("midramp_duty", int'(cur_duty), 2);
`else
        check("midramp_duty", int'(cur_duty), 9);
`endif
        check("midramp_busy", int'(busy), 1);
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_duty", int'(cur_duty), 0);
        check("async_rst_busy", int'(busy), 0);
        check("async_rst_pwm", int'(pwm_out), 0);
        check("async_rst_ready", int'(req_ready), 0);
        @(negedge clk);
        rst = 1'b0;
        quiet = 1'b1;
        for (int i = 0; i < 3 * PERIOD; i++) begin
            @(negedge clk);
            if (busy || cur_duty != 4'd0) quiet = 1'b0;
        end
        check("no_resume", int'(quiet), 1);
        measure_high("after_rst_pwm_high", 4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
